scene_sequencer: RTL

//  Frame-rate controller for the VGA graphics engine. Counts frames from v_sync.

---
 rtl/scene_sequencer_if.sv | 27 ++
 rtl/scene_sequencer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/scene_sequencer_if.sv
// Control bundle between the VGA timing side and the graphics engine.
// The master drives v_sync/pause/skip; the sequencer (slave) drives the
// scene state and layer controls back.
interface scene_sequencer_if #(
  parameter int CTR_W = 10
);
  logic             v_sync;
  logic             pause;
  logic             skip;
  logic             frame_tick;
  logic [1:0]       scene;
  logic [CTR_W-1:0] anim_ctr;
  logic             overlay_en;
  logic             sine_en;
  logic             sine_bg_en;
  logic [1:0]       fade_level;

  modport master (
    output v_sync, pause, skip,
    input  frame_tick, scene, anim_ctr, overlay_en, sine_en, sine_bg_en, fade_level
  );

  modport slave (
    input  v_sync, pause, skip,
    output frame_tick, scene, anim_ctr, overlay_en, sine_en, sine_bg_en, fade_level
  );
endinterface

// File: rtl/scene_sequencer.sv
// Frame-rate scene sequencer: counts frames from v_sync rising edges, steps
// INTRO -> SCROLL -> FADE -> BLANK -> INTRO and drives the render controls
// (animation counter, layer enables, fade level) as registered outputs.
module scene_sequencer #(
  parameter int INTRO_FRAMES  = 120,
  parameter int SCROLL_FRAMES = 600,
  parameter int FADE_STEP     = 16,
  parameter int BLANK_FRAMES  = 30,
  parameter int CTR_W         = 10
) (
  input  logic               clk,
  input  logic               rst,
  scene_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    INTRO  = 2'd0,
    SCROLL = 2'd1,
    FADE   = 2'd2,
    BLANK  = 2'd3
  } scene_t;

  // Last dwell value of each scene; dwell resets to 0 on every scene change.
  localparam logic [9:0] LAST_INTRO  = 10'(INTRO_FRAMES - 1);
  localparam logic [9:0] LAST_SCROLL = 10'(SCROLL_FRAMES - 1);
  localparam logic [9:0] LAST_FADE   = 10'(4 * FADE_STEP - 1);
  localparam logic [9:0] LAST_BLANK  = 10'(BLANK_FRAMES - 1);

  // Fade level thresholds: level drops by one every FADE_STEP frames.
  localparam logic [9:0] FADE_T1 = 10'(FADE_STEP);
  localparam logic [9:0] FADE_T2 = 10'(2 * FADE_STEP);
  localparam logic [9:0] FADE_T3 = 10'(3 * FADE_STEP);

  scene_t           scene_reg, scene_next;
  logic [9:0]       dwell_reg, dwell_next;
  logic [CTR_W-1:0] anim_reg, anim_next;
  logic             v_sync_q_reg;
  logic             frame_tick_reg;
  logic             overlay_reg, overlay_next;
  logic             sine_reg, sine_next;
  logic             sine_bg_reg, sine_bg_next;
  logic [1:0]       fade_reg, fade_next;

  logic             tick;
  logic             count_en;
  logic [9:0]       dwell_last;

  assign tick     = bus.v_sync & ~v_sync_q_reg;
  assign count_en = tick & ~bus.pause;

  // Dwell length of the current scene, as its final dwell value.
  always_comb begin
    dwell_last = LAST_INTRO;
    case (scene_reg)
      INTRO:   dwell_last = LAST_INTRO;
      SCROLL:  dwell_last = LAST_SCROLL;
      FADE:    dwell_last = LAST_FADE;
      BLANK:   dwell_last = LAST_BLANK;
      default: dwell_last = LAST_INTRO;
    endcase
  end

  // Next scene/dwell/counter; skip takes priority so only one step per edge,
  // while anim_ctr always follows the pre-edge scene.
  always_comb begin
    scene_next = scene_reg;
    dwell_next = dwell_reg;
    anim_next  = anim_reg;

    if (bus.skip) begin
      scene_next = scene_t'(scene_reg + 2'd1);
      dwell_next = 10'd0;
    end else if (count_en) begin
      if (dwell_reg == dwell_last) begin
        scene_next = scene_t'(scene_reg + 2'd1);
        dwell_next = 10'd0;
      end else begin
        dwell_next = dwell_reg + 10'd1;
      end
    end

    if (count_en && (scene_reg == SCROLL || scene_reg == FADE)) begin
      anim_next = anim_reg + CTR_W'(1);
    end
  end

  // Layer controls derived from the next state so they move with scene.
  always_comb begin
    overlay_next = 1'b1;
    sine_next    = 1'b0;
    sine_bg_next = 1'b0;
    fade_next    = 2'd3;
    case (scene_next)
      INTRO: begin
        overlay_next = 1'b1;
        fade_next    = 2'd3;
      end
      SCROLL: begin
        overlay_next = 1'b0;
        sine_next    = 1'b1;
        sine_bg_next = 1'b1;
        fade_next    = 2'd3;
      end
      FADE: begin
        overlay_next = 1'b0;
        sine_next    = 1'b1;
        sine_bg_next = 1'b1;
        if (dwell_next < FADE_T1)      fade_next = 2'd3;
        else if (dwell_next < FADE_T2) fade_next = 2'd2;
        else if (dwell_next < FADE_T3) fade_next = 2'd1;
        else                           fade_next = 2'd0;
      end
      BLANK: begin
        overlay_next = 1'b0;
        fade_next    = 2'd0;
      end
      default: begin
        overlay_next = 1'b1;
        fade_next    = 2'd3;
      end
    endcase
  end

  // State and output registers; v_sync_q resets high so a v_sync already
  // high at reset release does not count as a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      scene_reg      <= INTRO;
      dwell_reg      <= 10'd0;
      anim_reg       <= '0;
      v_sync_q_reg   <= 1'b1;
      frame_tick_reg <= 1'b0;
      overlay_reg    <= 1'b1;
      sine_reg       <= 1'b0;
      sine_bg_reg    <= 1'b0;
      fade_reg       <= 2'd3;
    end else begin
      scene_reg      <= scene_next;
      dwell_reg      <= dwell_next;
      anim_reg       <= anim_next;
      v_sync_q_reg   <= bus.v_sync;
      frame_tick_reg <= tick;
      overlay_reg    <= overlay_next;
      sine_reg       <= sine_next;
      sine_bg_reg    <= sine_bg_next;
      fade_reg       <= fade_next;
    end
  end

  assign bus.frame_tick = frame_tick_reg;
  assign bus.scene      = scene_reg;
  assign bus.anim_ctr   = anim_reg;
  assign bus.overlay_en = overlay_reg;
  assign bus.sine_en    = sine_reg;
  assign bus.sine_bg_en = sine_bg_reg;
  assign bus.fade_level = fade_reg;

endmodule
